uart_alu_intf: RTL and testbench

- Command/response engine on the user side of the UART top: pops operand/opcode bytes from the RX FIFO read port, executes one ALU operation, pushes the result byte into the TX FIFO write port.
- Frame on the wire: A, B, OP (three bytes, in that order). Response: one result byte, plus an optional flags byte.
- Connects directly to the UART's rd_uart/rx_empty/r_data and wr_uart/tx_full/w_data.

---
 rtl/uart_alu_intf_pkg.sv | 52 +++++
 rtl/uart_alu_intf_alu.sv | 59 +++++
 rtl/uart_alu_intf.sv | 141 ++++++++++++++
 tb/tb_uart_alu_intf.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_intf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : uart_alu_intf_pkg                                              |
// | Purpose   : Shared opcodes, FSM state encoding and flag bit positions for  |
// |             the UART command/response ALU engine.                          |
// | Options   : UART_ALU_FLAGS_EN adds the SEND_FLAGS state.                   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package uart_alu_intf_pkg;

  // Opcodes, taken from the low 6 bits of the OP byte
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  // Bit positions inside the flags byte
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_CARRY   = 1;
  localparam int FLAG_INVALID = 2;
  localparam int FLAG_W       = 3;

  typedef enum logic [2:0] {
    ST_GET_A      = 3'd0,
    ST_GET_B      = 3'd1,
    ST_GET_OP     = 3'd2,
    ST_EXEC       = 3'd3,
`ifdef UART_ALU_FLAGS_EN
    ST_SEND       = 3'd4,
    ST_SEND_FLAGS = 3'd5
`else
    ST_SEND       = 3'd4
`endif
  } state_t;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic invalid,
                                                   input logic carry,
                                                   input logic zero);
    logic [FLAG_W-1:0] f;
    f               = '0;
    f[FLAG_ZERO]    = zero;
    f[FLAG_CARRY]   = carry;
    f[FLAG_INVALID] = invalid;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_alu_intf_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : uart_alu_intf_alu                                              |
// | Purpose   : Purely combinational ALU used by the UART command engine.      |
// | Ports     : a, b     - operands (DBIT)                                     |
// |             op       - opcode (NB_OP)                                      |
// |             result   - operation result (DBIT)                             |
// |             carry    - ADD carry-out / SUB borrow, 0 otherwise             |
// |             zero     - result == 0                                         |
// |             invalid  - opcode not recognised (result forced to 0)          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module uart_alu_intf_alu
  import uart_alu_intf_pkg::*;
#(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
) (
  input  logic [DBIT-1:0]  a,
  input  logic [DBIT-1:0]  b,
  input  logic [NB_OP-1:0] op,
  output logic [DBIT-1:0]  result,
  output logic             carry,
  output logic             zero,
  output logic             invalid
);

  logic [DBIT:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b};
  assign zero  = (result == '0);

  always_comb begin
    result  = '0;
    carry   = 1'b0;
    invalid = 1'b0;
    case (op)
      NB_OP'(OP_ADD): begin
        result = w_sum[DBIT-1:0];
        carry  = w_sum[DBIT];
      end
      NB_OP'(OP_SUB): begin
        result = a - b;
        carry  = (a < b);
      end
      NB_OP'(OP_AND): result = a & b;
      NB_OP'(OP_OR):  result = a | b;
      NB_OP'(OP_XOR): result = a ^ b;
      NB_OP'(OP_NOR): result = ~(a | b);
      // Shift amount is the full unsigned B; oversize shifts saturate to
      // all-sign-bits (SRA) or zero (SRL).
      NB_OP'(OP_SRA): result = $signed(a) >>> b;
      NB_OP'(OP_SRL): result = a >> b;
      default:        invalid = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uart_alu_intf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : uart_alu_intf                                                  |
// | Purpose   : Command/response engine between the UART FIFOs and an ALU.     |
// |             Pops A, B, OP from the RX FIFO, executes, pushes the result    |
// |             (and optionally a flags byte) into the TX FIFO.                |
// | Ports     : clk, reset (sync, active-low)                                  |
// |             rx_empty, r_data, rd_uart   - RX FIFO read port (FWFT)         |
// |             tx_full, w_data, wr_uart    - TX FIFO write port               |
// |             busy                        - high outside GET_A               |
// |             result                      - last computed result             |
// | Options   : `define UART_ALU_FLAGS_EN to send {invalid,carry,zero} after   |
// |             the result byte.                                               |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module uart_alu_intf
  import uart_alu_intf_pkg::*;
#(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic            busy,
  output logic [DBIT-1:0] result
);

  state_t             r_state;
  logic [DBIT-1:0]    r_a;
  logic [DBIT-1:0]    r_b;
  logic [NB_OP-1:0]   r_op;
  logic [DBIT-1:0]    r_result;

  logic [DBIT-1:0]    w_alu_result;
  logic               w_carry;
  logic               w_zero;
  logic               w_invalid;
  logic               w_get;

`ifdef UART_ALU_FLAGS_EN
  logic [FLAG_W-1:0]  r_flags;
`else
  logic               w_unused_flags;
  assign w_unused_flags = ^{w_carry, w_zero, w_invalid};
`endif

  uart_alu_intf_alu #(
    .DBIT  (DBIT),
    .NB_OP (NB_OP)
  ) u_alu (
    .a       (r_a),
    .b       (r_b),
    .op      (r_op),
    .result  (w_alu_result),
    .carry   (w_carry),
    .zero    (w_zero),
    .invalid (w_invalid)
  );

  assign w_get  = (r_state == ST_GET_A) || (r_state == ST_GET_B) ||
                  (r_state == ST_GET_OP);
  assign result = r_result;

  // Handshakes are Mealy on the FIFO flags; all outputs are held quiet while
  // reset is asserted so the cycle that carries reset never moves data.
  always_comb begin
    rd_uart = reset && w_get && !rx_empty;
    wr_uart = 1'b0;
    w_data  = '0;
    busy    = reset && (r_state != ST_GET_A);
    if (reset) begin
      case (r_state)
        ST_SEND: begin
          w_data  = r_result;
          wr_uart = !tx_full;
        end
`ifdef UART_ALU_FLAGS_EN
        ST_SEND_FLAGS: begin
          w_data  = {{(DBIT-FLAG_W){1'b0}}, r_flags};
          wr_uart = !tx_full;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_GET_A;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
`ifdef UART_ALU_FLAGS_EN
      r_flags  <= '0;
`endif
    end else begin
      case (r_state)
        ST_GET_A: if (!rx_empty) begin
          r_a     <= r_data;
          r_state <= ST_GET_B;
        end
        ST_GET_B: if (!rx_empty) begin
          r_b     <= r_data;
          r_state <= ST_GET_OP;
        end
        ST_GET_OP: if (!rx_empty) begin
          r_op    <= r_data[NB_OP-1:0];
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_result <= w_alu_result;
`ifdef UART_ALU_FLAGS_EN
          r_flags  <= pack_flags(w_invalid, w_carry, w_zero);
`endif
          r_state  <= ST_SEND;
        end
        ST_SEND: if (!tx_full) begin
`ifdef UART_ALU_FLAGS_EN
          r_state <= ST_SEND_FLAGS;
`else
          r_state <= ST_GET_A;
`endif
        end
`ifdef UART_ALU_FLAGS_EN
        ST_SEND_FLAGS: if (!tx_full) r_state <= ST_GET_A;
`endif
        default: r_state <= ST_GET_A;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_intf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_uart_alu_intf                                               |
// | Purpose   : Self-checking bench for uart_alu_intf with behavioural FIFOs   |
// |             and an arithmetic reference model of the ALU.                  |
// | Options   : UART_ALU_FLAGS_EN must match the RTL build.                    |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_uart_alu_intf;

`ifdef UART_ALU_FLAGS_EN
  localparam int NRESP = 2;
`else
  localparam int NRESP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       tx_full = 1'b0;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       busy;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int         rd_cyc[$];
  int         wr_cyc[$];
  int         cyc  = 0;
  int         viol = 0;

  always #5 clk = ~clk;

  uart_alu_intf #(.DBIT(8), .NB_OP(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .busy     (busy),
    .result   (result)
  );

  // Behavioural FWFT RX FIFO, TX sink and handshake monitor.
  initial begin : fifo_model
    logic s_rd, s_wr, s_full, s_empty, s_rst;
    logic [7:0] s_wd;
    forever begin
      @(posedge clk);
      s_rd = rd_uart; s_wr = wr_uart; s_wd = w_data;
      s_full = tx_full; s_empty = rx_empty; s_rst = reset;
      cyc++;
      #1;
      if (s_rd && s_wr) viol++;
      if (s_rd && s_empty) viol++;
      if (s_wr && s_full) viol++;
      if (!s_rst && (s_rd || s_wr)) viol++;
      if (s_rd) begin
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        rd_cyc.push_back(cyc);
      end
      if (s_wr) begin
        tx_q.push_back(s_wd);
        wr_cyc.push_back(cyc);
      end
      rx_empty = (rx_q.size() == 0);
      r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      @(negedge clk);
      #1;
      rx_empty = (rx_q.size() == 0);
      r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  // Reference model: returns {invalid, carry, zero, result[7:0]}.
  function automatic logic [10:0] model(input int a, input int b, input int op);
    int o, r;
    bit c, inv;
    o = op % 64; r = 0; c = 0; inv = 0;
    case (o)
      32: begin r = a + b; c = (r > 255); r = r % 256; end
      34: begin c = (a < b); r = (a - b + 256) % 256; end
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = 255 - (a | b);
      3: begin
        if (b >= 8) r = (a >= 128) ? 255 : 0;
        else begin
          r = a / (2 ** b);
          if (a >= 128) r = r + 256 - (2 ** (8 - b));
        end
      end
      2: r = (b >= 8) ? 0 : a / (2 ** b);
      default: inv = 1;
    endcase
    return {inv, c, (r == 0), 8'(r)};
  endfunction

  function automatic logic [7:0] model_flags(input logic [10:0] m);
    return {5'b0, m[10:8]};
  endfunction

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    @(negedge clk);
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(op);
  endtask

  task automatic get_resp(input int budget, output bit ok, output logic [7:0] res,
                          output logic [7:0] flg);
    int n;
    n = 0; ok = 0; res = 8'h00; flg = 8'h00;
    while (tx_q.size() < NRESP && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx_q.size() >= NRESP) begin
      ok  = 1;
      res = tx_q.pop_front();
`ifdef UART_ALU_FLAGS_EN
      flg = tx_q.pop_front();
`endif
    end
  endtask

  task automatic wait_pops(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (rd_cyc.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (rd_cyc.size() >= target);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rx_q.push_back(8'hAA);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rd_uart !== 1'b0 || wr_uart !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: rd=%b wr=%b expected 0 0", rd_uart, wr_uart);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (w_data !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %02h expected 00", w_data); end
    checks++;
    if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %02h expected 00", result); end
    rx_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_cyc.size() !== 0) begin
      errors++; $display("FAIL reset_idle: busy=%b pops=%0d expected 0 0", busy, rd_cyc.size());
    end
  endtask

  task automatic test_basic();
    int n_rd, n_wr;
    bit ok;
    logic [7:0] res, flg;
    n_rd = rd_cyc.size(); n_wr = wr_cyc.size();
    send_frame(8'h05, 8'h03, 8'h20);
    get_resp(100, ok, res, flg);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: got no response expected %0d bytes", NRESP); end
    checks++;
    if (res !== 8'h08) begin errors++; $display("FAIL basic_wdata: got %02h expected 08", res); end
    checks++;
    if (result !== 8'h08) begin errors++; $display("FAIL basic_result: got %02h expected 08", result); end
`ifdef UART_ALU_FLAGS_EN
    checks++;
    if (flg !== 8'h00) begin errors++; $display("FAIL basic_flags: got %02h expected 00", flg); end
`endif
    checks++;
    if (rd_cyc.size() - n_rd !== 3) begin
      errors++; $display("FAIL basic_pops: got %0d expected 3", rd_cyc.size() - n_rd);
    end else begin
      checks++;
      if (rd_cyc[n_rd+2] - rd_cyc[n_rd] !== 2) begin
        errors++; $display("FAIL basic_pop_spacing: got %0d expected 2", rd_cyc[n_rd+2] - rd_cyc[n_rd]);
      end
      if (wr_cyc.size() > n_wr) begin
        checks++;
        if (wr_cyc[n_wr] - rd_cyc[n_rd+2] !== 2) begin
          errors++; $display("FAIL basic_latency: got %0d expected 2", wr_cyc[n_wr] - rd_cyc[n_rd+2]);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_directed();
    logic [7:0] ta [7] = '{8'h80, 8'h80, 8'h81, 8'hFF, 8'h01, 8'h12, 8'hF0};
    logic [7:0] tb [7] = '{8'h02, 8'h02, 8'h09, 8'h01, 8'h02, 8'h34, 8'h0F};
    logic [7:0] top[7] = '{8'h03, 8'h02, 8'h03, 8'h20, 8'h22, 8'h24, 8'h27};
    logic [7:0] tex[7] = '{8'hE0, 8'h20, 8'hFF, 8'h00, 8'hFF, 8'h10, 8'h00};
    bit ok;
    logic [7:0] res, flg;
    logic [10:0] m;
    for (int i = 0; i < 7; i++) begin
      send_frame(ta[i], tb[i], top[i]);
      get_resp(100, ok, res, flg);
      m = model(int'(ta[i]), int'(tb[i]), int'(top[i]));
      checks++;
      if (!ok || res !== tex[i]) begin
        errors++; $display("FAIL directed_%0d: got %02h ok=%0b expected %02h", i, res, ok, tex[i]);
      end
      checks++;
      if (result !== tex[i]) begin
        errors++; $display("FAIL directed_result_%0d: got %02h expected %02h", i, result, tex[i]);
      end
`ifdef UART_ALU_FLAGS_EN
      checks++;
      if (flg !== model_flags(m)) begin
        errors++; $display("FAIL directed_flags_%0d: got %02h expected %02h", i, flg, model_flags(m));
      end
`endif
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bytes [3] = '{8'h5A, 8'h3C, 8'h3F};
    int n_rd;
    bit ok;
    logic [7:0] res, flg;
    n_rd = rd_cyc.size();
    for (int i = 0; i < 3; i++) begin
      repeat (50) @(negedge clk);
      checks++;
      if (rd_cyc.size() !== n_rd + i || busy !== (i > 0)) begin
        errors++; $display("FAIL gap_hold_%0d: pops=%0d busy=%b expected %0d %b",
                           i, rd_cyc.size() - n_rd, busy, i, (i > 0));
      end
      rx_q.push_back(bytes[i]);
    end
    get_resp(100, ok, res, flg);
    checks++;
    if (!ok || res !== 8'h00) begin errors++; $display("FAIL gap_invalid: got %02h ok=%0b expected 00", res, ok); end
`ifdef UART_ALU_FLAGS_EN
    checks++;
    if (flg !== 8'h05) begin errors++; $display("FAIL gap_flags: got %02h expected 05", flg); end
`endif
  endtask

  task automatic test_backpressure();
    int n_rd, n_wr, c_rel, last;
    bit ok, stall_bad;
    logic [7:0] res, flg;
    n_rd = rd_cyc.size(); n_wr = wr_cyc.size();
    @(negedge clk);
    tx_full = 1'b1;
    send_frame(8'h33, 8'h44, 8'h26);
    send_frame(8'h10, 8'h20, 8'h20);
    wait_pops(n_rd + 3, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_pop_timeout: got %0d pops expected 3", rd_cyc.size() - n_rd); end
    @(negedge clk);
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (wr_uart !== 1'b0 || w_data !== 8'h77) begin
        errors++; stall_bad = 1;
        $display("FAIL bp_stall_%0d: wr=%b wdata=%02h expected 0 77", i, wr_uart, w_data);
      end
    end
    checks++;
    if (rd_cyc.size() !== n_rd + 3 || wr_cyc.size() !== n_wr) begin
      errors++; $display("FAIL bp_no_traffic: pops=%0d pushes=%0d expected 3 0",
                         rd_cyc.size() - n_rd, wr_cyc.size() - n_wr);
    end
    c_rel = cyc;
    tx_full = 1'b0;
    get_resp(50, ok, res, flg);
    checks++;
    if (!ok || res !== 8'h77) begin errors++; $display("FAIL bp_result: got %02h ok=%0b expected 77", res, ok); end
    if (wr_cyc.size() >= n_wr + NRESP) begin
      checks++;
      if (wr_cyc[n_wr] !== c_rel + 1) begin
        errors++; $display("FAIL bp_push_cycle: got %0d expected %0d", wr_cyc[n_wr], c_rel + 1);
      end
      last = wr_cyc[n_wr + NRESP - 1];
      wait_pops(n_rd + 4, 20, ok);
      checks++;
      if (!ok || rd_cyc[rd_cyc.size()-1] !== last + 1 || rd_cyc.size() !== n_rd + 4) begin
        errors++; $display("FAIL back_to_back_pop: got cycle %0d expected %0d",
                           rd_cyc[rd_cyc.size()-1], last + 1);
      end
    end
    get_resp(100, ok, res, flg);
    checks++;
    if (!ok || res !== 8'h30) begin errors++; $display("FAIL back_to_back_result: got %02h ok=%0b expected 30", res, ok); end
    if (stall_bad) $display("note: stall window errors above");
  endtask

  task automatic test_reset_midframe();
    int n_rd, n_wr;
    bit ok;
    logic [7:0] res, flg;
    n_rd = rd_cyc.size(); n_wr = wr_cyc.size();
    @(negedge clk);
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    wait_pops(n_rd + 2, 50, ok);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rd_uart !== 1'b0 || wr_uart !== 1'b0) begin
        errors++; $display("FAIL midreset_%0d: busy=%b rd=%b wr=%b expected 0 0 0", i, busy, rd_uart, wr_uart);
      end
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cyc.size() !== n_wr || tx_q.size() !== 0) begin
      errors++; $display("FAIL midreset_no_push: got %0d pushes expected 0", wr_cyc.size() - n_wr);
    end
    send_frame(8'h0F, 8'hF0, 8'h25);
    get_resp(100, ok, res, flg);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || res !== 8'hFF || wr_cyc.size() !== n_wr + NRESP) begin
      errors++; $display("FAIL midreset_frame: got %02h pushes=%0d expected FF %0d",
                         res, wr_cyc.size() - n_wr, NRESP);
    end
  endtask

  task automatic test_random();
    int ops [8] = '{32, 34, 36, 37, 38, 39, 3, 2};
    int a, b, op;
    bit ok;
    logic [7:0] res, flg;
    logic [10:0] m;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom_range(0, 255);
      b  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : $urandom_range(0, 255);
      op = ($urandom_range(0, 4) != 0) ? ops[$urandom_range(0, 7)] + 64 * $urandom_range(0, 3)
                                       : $urandom_range(0, 255);
      m  = model(a, b, op);
      @(negedge clk);
      rx_q.push_back(8'(a));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rx_q.push_back(8'(b));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rx_q.push_back(8'(op));
      get_resp(100, ok, res, flg);
      checks++;
      if (!ok || res !== m[7:0] || result !== m[7:0]) begin
        errors++; $display("FAIL random_%0d a=%02h b=%02h op=%02h: got %02h/%02h expected %02h",
                           i, a, b, op, res, result, m[7:0]);
      end
`ifdef UART_ALU_FLAGS_EN
      checks++;
      if (flg !== model_flags(m)) begin
        errors++; $display("FAIL random_flags_%0d: got %02h expected %02h", i, flg, model_flags(m));
      end
`endif
    end
  endtask

  task automatic test_protocol();
    repeat (3) @(negedge clk);
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL handshake_rules: got %0d violations expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_gaps();
    test_backpressure();
    test_reset_midframe();
    test_random();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
